// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, byte count and fetch FSM encodings for the IF stage.
package if_fetch_unit_pkg;
    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;
    localparam int INST_BYTES      = 4;
    localparam int BYTE_W          = 8;
    localparam int CNT_W           = $clog2(INST_BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;
endpackage

// File: rtl/if_byte_asm.sv
// if_byte_asm: byte counter and little-endian lane writes assembling one instruction.
module if_byte_asm
    import if_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [CNT_W-1:0]      cnt,
    output logic [INST_BUS_W-1:0] data,
    output logic                  done
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            data <= '0;
        end else if (clr) begin
            cnt  <= '0;
            data <= '0;
        end else if (wr) begin
            data[BYTE_W*cnt +: BYTE_W] <= wdata;
            cnt                        <= cnt + 1'b1;
        end
    end

    assign done = cnt == CNT_W'(INST_BYTES - 1);
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetches a 32-bit instruction as four byte reads and presents it to ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS_W,
    parameter int INST_W = INST_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              stallreq_o,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i
);
    fetch_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q;
    logic [CNT_W-1:0]      cnt;
    logic [INST_BUS_W-1:0] inst_buf;
    logic                  last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && !flush_i)
                pc_q <= pc_i;
        end
    end

    // flush outranks every other event; a granted byte must still be drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = flush_i ? S_IDLE : S_REQ;
            S_REQ:   state_d = flush_i ? (mem_gnt_i ? S_DRAIN : S_IDLE)
                                       : (mem_gnt_i ? S_WAIT : S_REQ);
            S_WAIT:  state_d = flush_i ? (mem_rvalid_i ? S_IDLE : S_DRAIN)
                                       : (mem_rvalid_i ? (last ? S_DONE : S_REQ) : S_WAIT);
            S_DONE:  state_d = (flush_i || !stall_i) ? S_IDLE : S_DONE;
            S_DRAIN: state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = state_q == S_REQ;
        mem_addr_o = mem_req_o ? pc_q + ADDR_W'(cnt) : '0;
        if_valid_o = state_q == S_DONE;
        if_pc_o    = if_valid_o ? pc_q : '0;
        if_inst_o  = if_valid_o ? INST_W'(inst_buf) : '0;
        stallreq_o = !(if_valid_o && !stall_i && !flush_i);
    end

    if_byte_asm u_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == S_IDLE),
        .wr    (state_q == S_WAIT && mem_rvalid_i && !flush_i),
        .wdata (mem_rdata_i),
        .cnt   (cnt),
        .data  (inst_buf),
        .done  (last)
    );
endmodule
